// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit. It holds the
// default word width, the operation encodings driven by the decoder on op_i,
// and the FSM state encoding. It has no ports.
package muldiv_unit_pkg;

    localparam int WORD_WIDTH  = 32;

    localparam int MD_OP_WIDTH = 3;
    localparam logic [MD_OP_WIDTH-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_MTLO  = 3'd5;

    localparam int MD_ST_WIDTH = 2;
    typedef enum logic [MD_ST_WIDTH-1:0] {
        MD_ST_IDLE  = 2'd0,
        MD_ST_RUN   = 2'd1,
        MD_ST_FIXUP = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_iter.sv
// muldiv_iter
// One combinational iteration over the 2W-bit accumulator.
//   isDiv_i   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i     : accumulator before the step
//   operand_i : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o     : accumulator after the step
// Multiply: the upper half collects partial sums and the lower half holds the
// multiplier, which shifts out LSB first.
// Divide: the upper half holds the partial remainder and the lower half holds
// the dividend, which shifts out MSB first while quotient bits shift in.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           isDiv_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   operand_i,
    output logic [2*W-1:0] acc_o
);
    logic [W:0] addSum;
    logic [W:0] shRem;
    logic [W:0] diff;

    // The extra top bit holds the multiply carry on one side and the
    // subtract borrow on the other.
    always_comb begin
        addSum = {1'b0, acc_i[2*W-1:W]} + {1'b0, operand_i};
        shRem  = acc_i[2*W-1:W-1];
        diff   = shRem - {1'b0, operand_i};
        if (isDiv_i) begin
            if (diff[W]) begin
                acc_o = {shRem[W-1:0], acc_i[W-2:0], 1'b0};
            end else begin
                acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {addSum, acc_i[W-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*W-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset
//   start_i : launch an op (taken only while idle)
//   op_i    : MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   a_i/b_i : rs / rt operands
//   flush_i : abort any in-flight op and block a same-cycle start
//   busy_o  : long op in progress
//   done_o  : one-cycle pulse once HI/LO hold the new result
//   hi_o/lo_o : HI and LO registers
// Signed ops run on magnitudes and apply the sign correction in FIXUP.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int W        = WORD_WIDTH,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [MD_OP_WIDTH-1:0] op_i,
    input  logic [W-1:0]           a_i,
    input  logic [W-1:0]           b_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [W-1:0]           hi_o,
    output logic [W-1:0]           lo_o
);
    localparam int CW = $clog2(W);

    md_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*W-1:0]         acc_q, acc_d, iterAcc;
    logic [W-1:0]           a_q, b_q, hi_q, hi_d, lo_q, lo_d;
    logic [MD_OP_WIDTH-1:0] op_q;
    logic                   negA_q, negB_q;
    logic                   done_q, done_d, fastPend_q, fastPend_d;

    logic                   inIsMul, inIsDiv, inSigned, inNegA, inNegB;
    logic                   launch, launchLong;
    logic [W-1:0]           inMagA, inMagB;

    logic                   opIsMul, sgnDiff, divByZero;
    logic [W-1:0]           magA, magB, iterOperand, quot, rem;
    logic [2*W-1:0]         mulRes, fastProd, fastRes;

    // Decode the request on the inputs. Only known ops launch; long ops are
    // the ones that go through RUN/FIXUP.
    always_comb begin
        inIsMul    = (op_i == MD_MULT) || (op_i == MD_MULTU);
        inIsDiv    = (op_i == MD_DIV) || (op_i == MD_DIVU);
        inSigned   = (op_i == MD_MULT) || (op_i == MD_DIV);
        inNegA     = inSigned & a_i[W-1];
        inNegB     = inSigned & b_i[W-1];
        inMagA     = inNegA ? -a_i : a_i;
        inMagB     = inNegB ? -b_i : b_i;
        launch     = (state_q == MD_ST_IDLE) && start_i && !flush_i &&
                     (inIsMul || inIsDiv || (op_i == MD_MTHI) || (op_i == MD_MTLO));
        launchLong = launch && (inIsDiv || (inIsMul && !FAST_MUL));
    end

    // Captured operands drive the iteration, the sign fixup and the fast
    // product. Negating MIN gives MIN, which is the correct unsigned magnitude.
    always_comb begin
        opIsMul     = (op_q == MD_MULT) || (op_q == MD_MULTU);
        sgnDiff     = negA_q ^ negB_q;
        magA        = negA_q ? -a_q : a_q;
        magB        = negB_q ? -b_q : b_q;
        iterOperand = opIsMul ? magA : magB;
        mulRes      = sgnDiff ? -acc_q : acc_q;
        quot        = sgnDiff ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem         = negA_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        divByZero   = (b_q == '0);
        fastProd    = {{W{1'b0}}, magA} * {{W{1'b0}}, magB};
        fastRes     = sgnDiff ? -fastProd : fastProd;
    end

    muldiv_iter #(.W(W)) u_iter (
        .isDiv_i   (!opIsMul),
        .acc_i     (acc_q),
        .operand_i (iterOperand),
        .acc_o     (iterAcc)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush drops any in-flight op back to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_ST_IDLE:  if (launchLong) state_d = MD_ST_RUN;
            MD_ST_RUN: begin
                if (flush_i) begin
                    state_d = MD_ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = MD_ST_FIXUP;
                end
            end
            MD_ST_FIXUP: state_d = MD_ST_IDLE;
            default:     state_d = MD_ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o = (state_q != MD_ST_IDLE);
        done_o = done_q;
        hi_o   = hi_q;
        lo_o   = lo_q;
    end

    // Datapath next values. A pending fast product is written first so that
    // an MTHI/MTLO launched on that same edge, being the younger op, wins.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        fastPend_d = 1'b0;
        if (fastPend_q) begin
            hi_d   = fastRes[2*W-1:W];
            lo_d   = fastRes[W-1:0];
            done_d = 1'b1;
        end
        unique case (state_q)
            MD_ST_IDLE: begin
                if (launch) begin
                    acc_d      = {{W{1'b0}}, (inIsMul ? inMagB : inMagA)};
                    cnt_d      = CW'(W - 1);
                    fastPend_d = inIsMul && FAST_MUL;
                    if (op_i == MD_MTHI) begin
                        hi_d   = a_i;
                        done_d = 1'b1;
                    end
                    if (op_i == MD_MTLO) begin
                        lo_d   = a_i;
                        done_d = 1'b1;
                    end
                end
            end
            MD_ST_RUN: begin
                if (!flush_i) begin
                    acc_d = iterAcc;
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                end
            end
            MD_ST_FIXUP: begin
                if (!flush_i) begin
                    if (opIsMul) begin
                        {hi_d, lo_d} = mulRes;
                    end else if (divByZero) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. Operands are captured only on launch, so later
    // changes on a_i/b_i do not disturb a running op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            fastPend_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            negA_q     <= 1'b0;
            negB_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            fastPend_q <= fastPend_d;
            if (launch) begin
                a_q    <= a_i;
                b_q    <= b_i;
                op_q   <= op_i;
                negA_q <= inNegA;
                negB_q <= inNegB;
            end
        end
    end
endmodule
